myproject_mul_12s_8ns_19_arb: RTL



---
 rtl/myproject_mul_12s_8ns_19_arb.sv | 107 ++++++++++
 1 files changed

// File: rtl/myproject_mul_12s_8ns_19_arb.sv
// Round-robin arbiter sharing one signed-12 x unsigned-8 multiplier among NREQ requesters.
// Two-stage pipeline (operand register, product register) with a completion counter.
module myproject_mul_12s_8ns_19_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*12-1:0]   req_a,
    input  logic [NREQ*8-1:0]    req_b,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [IDW-1:0]       res_id,
    output logic [18:0]          res_dout,
    output logic [CNTW-1:0]      ops_cnt,
    output logic                 busy
);

    logic [IDW-1:0]  rr_ptr_q;
    logic            s1_vld_q;
    logic [11:0]     s1_a_q;
    logic [7:0]      s1_b_q;
    logic [IDW-1:0]  s1_id_q;
    logic            res_vld_q;
    logic [IDW-1:0]  res_id_q;
    logic [18:0]     res_dout_q;
    logic [CNTW-1:0] ops_cnt_q;

    logic            adv;
    logic            accept;
    logic            gnt_found;
    logic [IDW-1:0]  gnt;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  ptr_nxt;
    logic signed [19:0] a_ext;
    logic signed [19:0] b_ext;
    logic signed [19:0] prod;

    // Search from rr_ptr upward modulo NREQ so indices >= NREQ are never visited.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
            if (!gnt_found && req_vld[cand]) begin
                gnt_found = 1'b1;
                gnt       = cand;
            end
        end
    end

    always_comb begin
        adv     = !res_vld_q || res_rdy;
        accept  = ap_rst_n && adv && gnt_found;
        req_rdy = accept ? (NREQ'(1) << gnt) : '0;
        ptr_nxt = (32'(gnt) == NREQ - 1) ? '0 : gnt + IDW'(1);
    end

    always_comb begin
        a_ext = {{8{s1_a_q[11]}}, s1_a_q};
        b_ext = {12'b0, s1_b_q};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            res_vld_q  <= 1'b0;
            res_id_q   <= '0;
            res_dout_q <= '0;
        end else if (adv) begin
            res_vld_q  <= s1_vld_q;
            res_id_q   <= s1_id_q;
            res_dout_q <= prod[18:0];
            s1_vld_q   <= accept;
            if (accept) begin
                s1_a_q   <= req_a[12*gnt +: 12];
                s1_b_q   <= req_b[8*gnt +: 8];
                s1_id_q  <= gnt;
                rr_ptr_q <= ptr_nxt;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ops_cnt_q <= '0;
        end else if (res_vld_q && res_rdy) begin
            ops_cnt_q <= ops_cnt_q + CNTW'(1);
        end
    end

    assign res_vld  = res_vld_q;
    assign res_id   = res_id_q;
    assign res_dout = res_dout_q;
    assign ops_cnt  = ops_cnt_q;
    assign busy     = s1_vld_q || res_vld_q;

endmodule
